axil_regbank: RTL and testbench

- Parametrised AXI4-Lite register bank replacing the hand-written per-core CPU register blocks (rtclock and others).
- Holds N 32-bit registers, each with its access mode chosen by mask: RW, RO, or RO clear-on-read.
- Provides atomic 64-bit snapshot pairs, WSTRB byte enables, independent AW/W acceptance and SLVERR on bad accesses.
- Sits between the AXI-Lite interconnect and the core datapath, in the S_AXI_ACLK domain only.

---
 rtl/axil_regbank_pkg.sv | 19 +
 rtl/axil_regbank_decode.sv | 20 ++
 rtl/axil_regbank.sv | 169 ++++++++++++++++
 tb/tb_axil_regbank.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_regbank_pkg.sv
// axil_regbank_pkg: shared response codes, FSM states and byte-merge helper
package axil_regbank_pkg;

    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [31:0] BAD_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    function automatic logic [31:0] strb_merge(input logic [31:0] old_v, input logic [31:0] new_v, input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        return r;
    endfunction

endpackage

// File: rtl/axil_regbank_decode.sv
// axil_regbank_decode: maps an AXI address to a register index and an in-range/aligned flag
module axil_regbank_decode
    import axil_regbank_pkg::*;
#(
    parameter int AW = 12,
    parameter logic [31:0] BASE = 32'h0,
    parameter int N = 16
) (
    input  logic [AW-1:0] addr,
    output logic [5:0]    idx,
    output logic          ok
);

    logic [AW-1:0] offset;

    assign offset = addr ^ BASE[AW-1:0];
    assign idx = offset[7:2];
    assign ok = (32'(offset) < 32'(4 * N)) && (offset[1:0] == 2'b00);

endmodule

// File: rtl/axil_regbank.sv
// axil_regbank: AXI4-Lite register bank with RW, RO, clear-on-read and atomic 64-bit pair registers
module axil_regbank
    import axil_regbank_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 12,
    parameter logic [31:0] C_BASE_ADDRESS = 32'h0,
    parameter int C_NUM_REGS = 16,
    parameter logic [63:0] C_RW_MASK = 64'h0,
    parameter logic [63:0] C_COR_MASK = 64'h0,
    parameter logic [31:0] C_PAIR_MASK = 32'h0,
    parameter logic [C_NUM_REGS*32-1:0] C_RW_DEFAULT = '0
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [C_NUM_REGS*32-1:0]        cpu2ip_regs,
    input  logic [C_NUM_REGS*32-1:0]        ip2cpu_regs,
    output logic [C_NUM_REGS-1:0]           ip_wr_pulse,
    output logic [C_NUM_REGS-1:0]           ip_rd_pulse
);

    localparam int NP = (C_NUM_REGS + 1) / 2;
    localparam logic [63:0] N_MASK = (C_NUM_REGS >= 64) ? {64{1'b1}} : ((64'd1 << C_NUM_REGS) - 64'd1);
    localparam logic [63:0] RW_M = C_RW_MASK & N_MASK;
    localparam logic [63:0] COR_M = C_COR_MASK & ~C_RW_MASK & N_MASK;

    // a pair is only honoured when both halves exist and neither is RW
    function automatic logic [31:0] pair_mask();
        logic [31:0] m;
        m = '0;
        for (int k = 0; k < 32; k++)
            m[k] = C_PAIR_MASK[k] && (2 * k + 1 < C_NUM_REGS) && !RW_M[2*k] && !RW_M[2*k+1];
        return m;
    endfunction

    localparam logic [31:0] PAIR_M = pair_mask();

    w_state_t w_state;
    r_state_t r_state;
    logic aw_held, w_held, aw_nxt, w_nxt, wok_a, wok, rok;
    logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q;
    logic [31:0] wdata_q, rd_data;
    logic [3:0] wstrb_q;
    logic [5:0] widx, ridx;
    logic [NP*32-1:0] shadow;
    logic [C_NUM_REGS*32+31:0] ip_ext;

    axil_regbank_decode #(.AW(C_S_AXI_ADDR_WIDTH), .BASE(C_BASE_ADDRESS), .N(C_NUM_REGS)) u_wdec (
        .addr(aw_addr_q), .idx(widx), .ok(wok_a)
    );

    axil_regbank_decode #(.AW(C_S_AXI_ADDR_WIDTH), .BASE(C_BASE_ADDRESS), .N(C_NUM_REGS)) u_rdec (
        .addr(S_AXI_ARADDR), .idx(ridx), .ok(rok)
    );

    assign wok = wok_a && RW_M[widx];
    assign aw_nxt = aw_held || (S_AXI_AWVALID && S_AXI_AWREADY);
    assign w_nxt = w_held || (S_AXI_WVALID && S_AXI_WREADY);
    assign ip_ext = {32'h0, ip2cpu_regs};

    // read data selection for the address currently on the AR channel
    always_comb begin
        rd_data = BAD_DATA;
        for (int i = 0; i < C_NUM_REGS; i++)
            if (rok && ridx == 6'(i))
                rd_data = RW_M[i] ? cpu2ip_regs[i*32 +: 32] :
                          (PAIR_M[i/2] && (i % 2 == 1)) ? shadow[(i/2)*32 +: 32] : ip2cpu_regs[i*32 +: 32];
    end

    // write channel: independent AW/W capture, one-cycle commit, response hold
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state <= W_IDLE;
            aw_held <= 1'b0;
            w_held <= 1'b0;
            aw_addr_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY <= 1'b0;
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP <= RESP_OKAY;
            ip_wr_pulse <= '0;
            cpu2ip_regs <= C_RW_DEFAULT;
        end else begin
            ip_wr_pulse <= '0;
            if (w_state == W_IDLE) begin
                if (S_AXI_AWVALID && S_AXI_AWREADY) aw_addr_q <= S_AXI_AWADDR;
                if (S_AXI_WVALID && S_AXI_WREADY) begin
                    wdata_q <= S_AXI_WDATA;
                    wstrb_q <= S_AXI_WSTRB;
                end
                aw_held <= aw_nxt;
                w_held <= w_nxt;
                S_AXI_AWREADY <= !aw_nxt;
                S_AXI_WREADY <= !w_nxt;
                w_state <= (aw_nxt && w_nxt) ? W_COMMIT : W_IDLE;
            end else if (w_state == W_COMMIT) begin
                for (int i = 0; i < C_NUM_REGS; i++)
                    if (wok && widx == 6'(i)) begin
                        cpu2ip_regs[i*32 +: 32] <= strb_merge(cpu2ip_regs[i*32 +: 32], wdata_q, wstrb_q);
                        ip_wr_pulse[i] <= 1'b1;
                    end
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP <= wok ? RESP_OKAY : RESP_SLVERR;
                w_state <= W_RESP;
            end else if (S_AXI_BREADY) begin
                S_AXI_BVALID <= 1'b0;
                aw_held <= 1'b0;
                w_held <= 1'b0;
                S_AXI_AWREADY <= 1'b1;
                S_AXI_WREADY <= 1'b1;
                w_state <= W_IDLE;
            end
        end
    end

    // read channel: sample at handshake, hold response until RREADY, COR strobe and pair snapshot
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA <= '0;
            S_AXI_RRESP <= RESP_OKAY;
            ip_rd_pulse <= '0;
            shadow <= '0;
        end else begin
            ip_rd_pulse <= '0;
            if (r_state == R_IDLE) begin
                if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                    r_state <= R_RESP;
                    S_AXI_ARREADY <= 1'b0;
                    S_AXI_RVALID <= 1'b1;
                    S_AXI_RDATA <= rd_data;
                    S_AXI_RRESP <= rok ? RESP_OKAY : RESP_SLVERR;
                    for (int i = 0; i < C_NUM_REGS; i++)
                        if (rok && ridx == 6'(i) && COR_M[i]) ip_rd_pulse[i] <= 1'b1;
                    for (int k = 0; k < NP; k++)
                        if (rok && ridx == 6'(2 * k) && PAIR_M[k]) shadow[k*32 +: 32] <= ip_ext[(2*k+1)*32 +: 32];
                end else begin
                    S_AXI_ARREADY <= 1'b1;
                end
            end else if (S_AXI_RREADY) begin
                r_state <= R_IDLE;
                S_AXI_RVALID <= 1'b0;
                S_AXI_ARREADY <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axil_regbank.sv
// tb_axil_regbank: directed stimulus with queued expected responses checked by a B/R channel monitor
module tb_axil_regbank;

    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic clk, rst_n;
    logic [11:0] awaddr, araddr;
    logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0] wstrb;
    logic [1:0] bresp, rresp;
    logic [511:0] cpu2ip, ip2cpu;
    logic [15:0] wr_pulse, rd_pulse;

    int total = 0;
    int bad = 0;
    logic [1:0] bq[$];
    logic [33:0] rq[$];
    logic [1:0] eb;
    logic [33:0] er;

    axil_regbank #(
        .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(12), .C_BASE_ADDRESS(32'h0), .C_NUM_REGS(16),
        .C_RW_MASK(64'h64), .C_COR_MASK(64'h8), .C_PAIR_MASK(32'h1), .C_RW_DEFAULT(512'h12345678)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .cpu2ip_regs(cpu2ip), .ip2cpu_regs(ip2cpu), .ip_wr_pulse(wr_pulse), .ip_rd_pulse(rd_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog act=running req=finished");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h req=%0h", nm, act, exp);
        end
    endtask

    // monitor: every B/R handshake pops the oldest expected response
    always @(negedge clk) begin
        if (rst_n && bvalid && bready) begin
            total++;
            if (bq.size() == 0) begin
                bad++;
                $display("FAIL b_unexpected act=%0h req=none", bresp);
            end else begin
                eb = bq.pop_front();
                if (bresp !== eb) begin
                    bad++;
                    $display("FAIL bresp act=%0h req=%0h", bresp, eb);
                end
            end
        end
        if (rst_n && rvalid && rready) begin
            total++;
            if (rq.size() == 0) begin
                bad++;
                $display("FAIL r_unexpected act=%0h/%0h req=none", rresp, rdata);
            end else begin
                er = rq.pop_front();
                if ({rresp, rdata} !== er) begin
                    bad++;
                    $display("FAIL rresp_rdata act=%0h/%0h req=%0h/%0h", rresp, rdata, er[33:32], er[31:0]);
                end
            end
        end
    end

    task automatic wait_wr_ready;
        for (int n = 0; n < 20 && !(awready && wready); n++) tick;
        chk("aw_w_ready_timeout", {63'b0, awready && wready}, 64'd1);
    endtask

    task automatic drain_b;
        for (int n = 0; n < 20 && bq.size() != 0; n++) tick;
        chk("b_drain_timeout", 64'(bq.size()), 64'd0);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] resp, input logic [15:0] pulse);
        bq.push_back(resp);
        wait_wr_ready;
        awaddr = a;
        wdata = d;
        wstrb = s;
        awvalid = 1'b1;
        wvalid = 1'b1;
        tick;
        awvalid = 1'b0;
        wvalid = 1'b0;
        tick;
        chk("wr_pulse", 64'(wr_pulse), 64'(pulse));
        bready = 1'b1;
        drain_b;
        bready = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] d, input logic [1:0] resp, input logic [15:0] pulse);
        rq.push_back({resp, d});
        for (int n = 0; n < 20 && !arready; n++) tick;
        chk("ar_ready_timeout", {63'b0, arready}, 64'd1);
        araddr = a;
        arvalid = 1'b1;
        rready = 1'b1;
        tick;
        arvalid = 1'b0;
        chk("rd_pulse", 64'(rd_pulse), 64'(pulse));
        for (int n = 0; n < 20 && rq.size() != 0; n++) tick;
        chk("r_drain_timeout", 64'(rq.size()), 64'd0);
        rready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        {awaddr, araddr, awvalid, wvalid, bready, arvalid, rready, wdata, wstrb} = '0;
        ip2cpu = '0;
        repeat (3) tick;
        chk("reset_cpu2ip0", 64'(cpu2ip[31:0]), 64'h12345678);
        chk("reset_readies", {61'b0, awready, wready, arready}, 64'd0);
        chk("reset_valids_pulses", {30'b0, bvalid, rvalid, wr_pulse, rd_pulse}, 64'd0);
        rst_n = 1'b1;
        tick;
        chk("readies_after_release", {61'b0, awready, wready, arready}, 64'h7);

        // W first, AW three cycles later, partial strobe to RW reg2
        bq.push_back(OKAY);
        wdata = 32'hAABBCCDD;
        wstrb = 4'b0101;
        wvalid = 1'b1;
        tick;
        wvalid = 1'b0;
        chk("wready_held_low", {63'b0, wready}, 64'd0);
        repeat (3) tick;
        chk("awready_still_high", {63'b0, awready}, 64'd1);
        awaddr = 12'h008;
        awvalid = 1'b1;
        tick;
        awvalid = 1'b0;
        chk("reg2_before_commit", 64'(cpu2ip[95:64]), 64'h0);
        tick;
        chk("reg2_after_commit", 64'(cpu2ip[95:64]), 64'h00BB00DD);
        chk("wr_pulse_reg2", 64'(wr_pulse), 64'h4);
        for (int c = 0; c < 5; c++) begin
            chk("bvalid_hold", {63'b0, bvalid}, 64'd1);
            tick;
            chk("wr_pulse_one_cycle", 64'(wr_pulse), 64'h0);
        end
        bready = 1'b1;
        drain_b;
        bready = 1'b0;
        chk("bvalid_dropped", {63'b0, bvalid}, 64'd0);

        // bad accesses
        wr(12'h010, 32'hFFFFFFFF, 4'hF, SLVERR, 16'h0);
        chk("reg4_slice_unchanged", 64'(cpu2ip[159:128]), 64'h0);
        chk("reg2_unchanged", 64'(cpu2ip[95:64]), 64'h00BB00DD);
        rd(12'h040, 32'hDEADBEEF, SLVERR, 16'h0);
        rd(12'h009, 32'hDEADBEEF, SLVERR, 16'h0);
        wr(12'h040, 32'h0, 4'hF, SLVERR, 16'h0);
        rd(12'h008, 32'h00BB00DD, OKAY, 16'h0);
        ip2cpu[159:128] = 32'hCAFEF00D;
        rd(12'h010, 32'hCAFEF00D, OKAY, 16'h0);

        // pair k=0
        ip2cpu[31:0] = 32'd1;
        ip2cpu[63:32] = 32'd2;
        rd(12'h004, 32'd0, OKAY, 16'h0);
        rd(12'h000, 32'd1, OKAY, 16'h0);
        ip2cpu[63:32] = 32'd9;
        rd(12'h004, 32'd2, OKAY, 16'h0);
        rd(12'h000, 32'd1, OKAY, 16'h0);
        rd(12'h004, 32'd9, OKAY, 16'h0);

        // COR reg3 with RREADY held low for 4 cycles
        ip2cpu[127:96] = 32'h55AA1234;
        rq.push_back({OKAY, 32'h55AA1234});
        for (int n = 0; n < 20 && !arready; n++) tick;
        chk("cor_ar_ready_timeout", {63'b0, arready}, 64'd1);
        araddr = 12'h00C;
        arvalid = 1'b1;
        tick;
        arvalid = 1'b0;
        chk("cor_pulse", 64'(rd_pulse), 64'h8);
        for (int c = 0; c < 3; c++) begin
            tick;
            chk("cor_pulse_width", 64'(rd_pulse), 64'h0);
            chk("cor_rvalid_hold", {63'b0, rvalid}, 64'd1);
            chk("cor_rdata_stable", 64'(rdata), 64'h55AA1234);
        end
        rready = 1'b1;
        for (int n = 0; n < 20 && rq.size() != 0; n++) tick;
        chk("cor_drain_timeout", 64'(rq.size()), 64'd0);
        rready = 1'b0;

        // reset while a write response is pending
        wait_wr_ready;
        awaddr = 12'h014;
        wdata = 32'h11111111;
        wstrb = 4'hF;
        awvalid = 1'b1;
        wvalid = 1'b1;
        tick;
        awvalid = 1'b0;
        wvalid = 1'b0;
        tick;
        chk("pending_bvalid", {63'b0, bvalid}, 64'd1);
        chk("reg5_written", 64'(cpu2ip[191:160]), 64'h11111111);
        rst_n = 1'b0;
        #1;
        chk("reset_drops_bvalid", {63'b0, bvalid}, 64'd0);
        chk("reset_restores_reg5", 64'(cpu2ip[191:160]), 64'h0);
        tick;
        rst_n = 1'b1;
        bready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick;
            chk("no_stale_bvalid", {63'b0, bvalid}, 64'd0);
        end
        bready = 1'b0;
        rd(12'h004, 32'd0, OKAY, 16'h0);
        wr(12'h018, 32'hABCD1234, 4'b1100, OKAY, 16'h40);
        chk("reg6_after_reset", 64'(cpu2ip[223:192]), 64'hABCD0000);
        rd(12'h018, 32'hABCD0000, OKAY, 16'h0);
        chk("reg2_after_reset", 64'(cpu2ip[95:64]), 64'h0);

        chk("b_queue_empty", 64'(bq.size()), 64'd0);
        chk("r_queue_empty", 64'(rq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
